// File: rtl/mem_wb_dmem_stage.sv
// MEM/WB stage with a word-addressed data memory and a fixed multi-cycle access latency.
// Latency: a memory op stalls for LATENCY cycles, then reaches WB_o on the edge ending DONE; non-mem ops take 1 edge.
// Backpressure: stall_o is combinational; it holds EX/MEM and earlier stages, and WB_o gets a bubble on stalled cycles.
// Optional feature macro: MISALIGN_CHK_EN. When it is defined, err_o exists and misaligned requests are flagged.
module mem_wb_dmem_stage #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ALUOut_i,
  input  logic [31:0] mux7_i,
  input  logic [4:0]  mux8_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [31:0] ALUOut_o,
  output logic [31:0] RDdata_o,
  output logic [4:0]  mux8_o
`ifdef MISALIGN_CHK_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // BUSY counts down from LATENCY-2; the IDLE cycle supplies the first stall cycle.
  localparam int              CNT_INIT_I = (LATENCY > 1) ? (LATENCY - 2) : 0;
  localparam logic [3:0]      CNT_INIT   = CNT_INIT_I[3:0];

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_data;
  logic            r_store;
  logic            r_mis;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic [AW-1:0]   w_idx;
  logic            w_mis;
  logic            w_stall;
  logic            w_acc_en;
  logic [AW-1:0]   w_acc_idx;
  logic [31:0]     w_acc_data;
  logic            w_acc_store;
  logic            w_acc_mis;
  logic            w_unused_bits;

  assign w_req = MemRead_i | MemWrite_i;
  assign w_idx = ALUOut_i[AW+1:2];
`ifdef MISALIGN_CHK_EN
  assign w_mis = |ALUOut_i[1:0];
`else
  assign w_mis = 1'b0;
`endif
  // Upper address bits are dropped so the address wraps modulo DEPTH words.
  assign w_unused_bits = ^{ALUOut_i[31:AW+2], ALUOut_i[1:0]};
  assign stall_o = w_stall;

  // Next-state, countdown and memory-access strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_acc_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          if (LATENCY == 1) begin
            w_acc_en    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_acc_en    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The access comes from the live inputs when it happens in the IDLE cycle (LATENCY==1), otherwise from the capture.
  always_comb begin
    w_acc_idx   = r_idx;
    w_acc_data  = r_data;
    w_acc_store = r_store;
    w_acc_mis   = r_mis;
    if (r_state == S_IDLE) begin
      w_acc_idx   = w_idx;
      w_acc_data  = mux7_i;
      w_acc_store = MemWrite_i;
      w_acc_mis   = w_mis;
    end
  end

  // FSM state, countdown and request capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_data  <= 32'd0;
      r_store <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && w_req) begin
        r_idx   <= w_idx;
        r_data  <= mux7_i;
        r_store <= MemWrite_i;
        r_mis   <= w_mis;
      end
    end
  end

  // Data memory and load-data register; contents are not reset, and reset blocks any access.
  always_ff @(posedge clk_i) begin
    if (w_acc_en && rst_i) begin
      if (w_acc_store) begin
        if (!w_acc_mis) begin
          r_mem[w_acc_idx] <= w_acc_data;
        end
      end else begin
        r_rdata <= w_acc_mis ? 32'd0 : r_mem[w_acc_idx];
      end
    end
  end

  // Registered MEM/WB outputs: bubble while stalled, retire the memory op in DONE, pass through otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WB_o     <= 2'b00;
      ALUOut_o <= 32'd0;
      RDdata_o <= 32'd0;
      mux8_o   <= 5'd0;
`ifdef MISALIGN_CHK_EN
      err_o    <= 1'b0;
`endif
    end else if (r_state == S_DONE) begin
      WB_o     <= (!r_store && r_mis) ? 2'b00 : WB_i;
      ALUOut_o <= ALUOut_i;
      mux8_o   <= mux8_i;
      RDdata_o <= r_store ? 32'd0 : r_rdata;
`ifdef MISALIGN_CHK_EN
      err_o    <= r_mis;
`endif
    end else if (w_stall) begin
      WB_o <= 2'b00;
    end else begin
      WB_o     <= WB_i;
      ALUOut_o <= ALUOut_i;
      mux8_o   <= mux8_i;
      RDdata_o <= 32'd0;
`ifdef MISALIGN_CHK_EN
      err_o    <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_wb_dmem_stage.sv
// Directed bench for mem_wb_dmem_stage: three instances with LATENCY 2, 1 and 4 share the data inputs.
// Only the instance selected by 'sel' sees MemRead/MemWrite; the others act as pass-through stages.
// Expected values are hand-computed constants; every comparison goes through check().
module tb_mem_wb_dmem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  wb_i;
  logic [31:0] alu_i;
  logic [31:0] m7_i;
  logic [4:0]  m8_i;
  logic        rd_i;
  logic        wr_i;
  int          sel;

  logic [2:0]        stall_w;
  logic [2:0][1:0]   wbo;
  logic [2:0][31:0]  aluo;
  logic [2:0][31:0]  rdo;
  logic [2:0][4:0]   m8o;
`ifdef MISALIGN_CHK_EN
  logic [2:0]        erro;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [4:0] last_m8;

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_wb_dmem_stage #(
      .DEPTH  (256),
      .AW     (8),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) u_dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .WB_i      (wb_i),
      .ALUOut_i  (alu_i),
      .mux7_i    (m7_i),
      .mux8_i    (m8_i),
      .MemRead_i (rd_i && (sel == g)),
      .MemWrite_i(wr_i && (sel == g)),
      .stall_o   (stall_w[g]),
      .WB_o      (wbo[g]),
      .ALUOut_o  (aluo[g]),
      .RDdata_o  (rdo[g]),
      .mux8_o    (m8o[g])
`ifdef MISALIGN_CHK_EN
      ,
      .err_o     (erro[g])
`endif
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one memory op on instance k at a sample point (#1 after posedge) and walk it to retirement.
  task automatic mem_op(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] wb, input logic [4:0] rdno,
                        input logic [31:0] exp_rd, input logic [1:0] exp_wb);
    sel = k; rd_i = rd; wr_i = wr; alu_i = addr; m7_i = data; wb_i = wb; m8_i = rdno;
    for (int c = 0; c < lat(k); c++) begin
      #1 check($sformatf("stall%0d_c%0d", k, c), 32'(stall_w[k]), 32'd1);
      @(posedge clk_i); #1;
      check($sformatf("bubble%0d_c%0d", k, c), 32'(wbo[k]), 32'd0);
      check($sformatf("m8hold%0d_c%0d", k, c), 32'(m8o[k]), 32'(last_m8));
    end
    #1 check($sformatf("done_nostall%0d", k), 32'(stall_w[k]), 32'd0);
    @(posedge clk_i); #1;
    check($sformatf("wb%0d", k),   32'(wbo[k]), 32'(exp_wb));
    check($sformatf("alu%0d", k),  aluo[k], addr);
    check($sformatf("rd%0d", k),   rdo[k], exp_rd);
    check($sformatf("m8_%0d", k),  32'(m8o[k]), 32'(rdno));
`ifdef MISALIGN_CHK_EN
    check($sformatf("err%0d", k), 32'(erro[k]), 32'(addr[1:0] != 2'b00));
`endif
    last_m8 = rdno;
    rd_i = 1'b0; wr_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; wb_i = 2'b00; alu_i = 32'd0; m7_i = 32'd0; m8_i = 5'd0;
    rd_i = 1'b0; wr_i = 1'b0; sel = 0; last_m8 = 5'd0;

    // Reset state while idle
    repeat (3) @(posedge clk_i);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_stall%0d", k), 32'(stall_w[k]), 32'd0);
      check($sformatf("rst_wb%0d", k),    32'(wbo[k]), 32'd0);
      check($sformatf("rst_alu%0d", k),   aluo[k], 32'd0);
      check($sformatf("rst_rd%0d", k),    rdo[k], 32'd0);
      check($sformatf("rst_m8_%0d", k),   32'(m8o[k]), 32'd0);
`ifdef MISALIGN_CHK_EN
      check($sformatf("rst_err%0d", k),   32'(erro[k]), 32'd0);
`endif
    end
    rst_i = 1'b1;

    // Non-memory op passes straight through in one edge
    wb_i = 2'b10; alu_i = 32'h1234; m8_i = 5'd5;
    #1 check("nop_stall", 32'(stall_w[0]), 32'd0);
    @(posedge clk_i); #1;
    check("nop_wb",  32'(wbo[0]), 32'd2);
    check("nop_alu", aluo[0], 32'h1234);
    check("nop_m8",  32'(m8o[0]), 32'd5);
    check("nop_rd",  rdo[0], 32'd0);
    last_m8 = 5'd5;

    // LATENCY=2: store then load the same word
    mem_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd3, 32'd0, 2'b00);
    mem_op(0, 1'b1, 1'b0, 32'h10, 32'h0,        2'b11, 5'd8, 32'hDEADBEEF, 2'b11);
    // Both MemRead and MemWrite high acts as a store
    mem_op(0, 1'b1, 1'b1, 32'h14, 32'h0BADF00D, 2'b11, 5'd9, 32'd0, 2'b11);
    mem_op(0, 1'b1, 1'b0, 32'h14, 32'h0,        2'b11, 5'd10, 32'h0BADF00D, 2'b11);

    // LATENCY=1: fill two words, then back-to-back loads
    mem_op(1, 1'b0, 1'b1, 32'h0, 32'h11111111, 2'b00, 5'd1, 32'd0, 2'b00);
    mem_op(1, 1'b0, 1'b1, 32'h4, 32'h22222222, 2'b00, 5'd2, 32'd0, 2'b00);
    mem_op(1, 1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 5'd6, 32'h11111111, 2'b11);
    mem_op(1, 1'b1, 1'b0, 32'h4, 32'h0, 2'b11, 5'd7, 32'h22222222, 2'b11);

    // LATENCY=4: reset pulse during BUSY drops the pending store
    mem_op(2, 1'b0, 1'b1, 32'h20, 32'hAAAA5555, 2'b00, 5'd4, 32'd0, 2'b00);
    sel = 2; wr_i = 1'b1; alu_i = 32'h20; m7_i = 32'h12345678; wb_i = 2'b00; m8_i = 5'd11;
    @(posedge clk_i); #1;
    check("busy_stall", 32'(stall_w[2]), 32'd1);
    rst_i = 1'b0; wr_i = 1'b0;
    #1;
    check("midrst_stall", 32'(stall_w[2]), 32'd0);
    check("midrst_wb",    32'(wbo[2]), 32'd0);
    check("midrst_alu",   aluo[2], 32'd0);
    check("midrst_m8",    32'(m8o[2]), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1; last_m8 = 5'd0;
    mem_op(2, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd12, 32'hAAAA5555, 2'b11);

    // Address wrap: upper bits ignored, 0x410 aliases word 0x10 (instance 0 memory survives reset)
    last_m8 = 5'd12;
    mem_op(0, 1'b1, 1'b0, 32'h410, 32'h0, 2'b11, 5'd13, 32'hDEADBEEF, 2'b11);

    // Misaligned store to 0x21 against word 0x20
    mem_op(0, 1'b0, 1'b1, 32'h20, 32'hCAFE0000, 2'b00, 5'd14, 32'd0, 2'b00);
    mem_op(0, 1'b0, 1'b1, 32'h21, 32'h55,       2'b00, 5'd15, 32'd0, 2'b00);
`ifdef MISALIGN_CHK_EN
    mem_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd16, 32'hCAFE0000, 2'b11);
    // Misaligned load returns zero and suppresses writeback
    mem_op(0, 1'b1, 1'b0, 32'h22, 32'h0, 2'b11, 5'd17, 32'd0, 2'b00);
`else
    mem_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd16, 32'h55, 2'b11);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
